fractal_pixel_engine: RTL



---
 rtl/fractal_pkg.sv | 24 ++
 rtl/fractal_pixel_engine_if.sv | 14 +
 rtl/fractal_iter_step.sv | 36 +++
 rtl/fractal_pixel_engine.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared types and helpers for the fractal pixel engine family:
// FSM encoding, mode values, escape threshold and grey colour map.
package fractal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic MODE_MANDEL = 1'b0;
    localparam logic MODE_JULIA  = 1'b1;

    // |z|^2 limit of 4.0 expressed in the same scaling as the squared terms.
    function automatic longint esc_threshold(input int frac_bits);
        return longint'(4) << frac_bits;
    endfunction

    function automatic logic [23:0] grey_map(input logic [7:0] level, input logic black);
        return black ? 24'h000000 : {level, level, level};
    endfunction

endpackage

// File: rtl/fractal_pixel_engine_if.sv
// Pixel stream bundle between the fractal engine and its downstream sink.
interface fractal_pixel_engine_if;
    // A beat transfers on a rising clock edge where tvalid && tready. Once tvalid
    // is high the master holds tdata/tuser/tlast stable until that transfer, and
    // tvalid never depends on tready.
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/fractal_iter_step.sv
// One combinational z <- z^2 + c step with the escape compare on the current z.
module fractal_iter_step
    import fractal_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [DATA_W-1:0] zr,
    input  logic signed [DATA_W-1:0] zi,
    input  logic signed [DATA_W-1:0] c_re,
    input  logic signed [DATA_W-1:0] c_im,
    output logic signed [DATA_W-1:0] zr_next,
    output logic signed [DATA_W-1:0] zi_next,
    output logic                     escape
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] THRESH = SW'(esc_threshold(FRAC_BITS));

    logic signed [PW-1:0] zr_w, zi_w, zr2, zi2, zri;
    logic signed [SW-1:0] mag;

    always_comb begin
        zr_w = PW'(zr);
        zi_w = PW'(zi);
        zr2  = (zr_w * zr_w) >>> FRAC_BITS;
        zi2  = (zi_w * zi_w) >>> FRAC_BITS;
        // One bit less of shift folds in the factor of two of 2*zr*zi.
        zri  = (zr_w * zi_w) >>> (FRAC_BITS - 1);
        mag  = SW'(zr2) + SW'(zi2);
        escape  = mag > THRESH;
        zr_next = DATA_W'(zr2 - zi2 + PW'(c_re));
        zi_next = DATA_W'(zri + PW'(c_im));
    end

endmodule

// File: rtl/fractal_pixel_engine.sv
// Raster walker running an escape-time Mandelbrot/Julia iteration per pixel and
// streaming one grey RGB beat per pixel with SOF on tuser and EOL on tlast.
module fractal_pixel_engine
    import fractal_pkg::*;
#(
    parameter int X_SIZE    = 1920,
    parameter int Y_SIZE    = 1080,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 8,
    parameter int ITER_W    = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cfg_enable,
    input  logic                     cfg_mode,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    input  logic signed [DATA_W-1:0] cfg_x0,
    input  logic signed [DATA_W-1:0] cfg_y0,
    input  logic signed [DATA_W-1:0] cfg_dx,
    input  logic signed [DATA_W-1:0] cfg_dy,
    input  logic signed [DATA_W-1:0] cfg_c_re,
    input  logic signed [DATA_W-1:0] cfg_c_im,
    fractal_pixel_engine_if.master   m,
    output logic                     busy,
    output logic                     frame_done,
    output state_t                   dbg_state
);
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    state_t state, state_next;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic signed [DATA_W-1:0] cur_re, cur_im, x0_s, dx_s, dy_s, c_re_s, c_im_s;
    logic signed [DATA_W-1:0] zr, zi, cr, ci, zr_next, zi_next;
    logic                mode_s;
    logic [ITER_W-1:0]   max_iter_s, iter;
    logic [23:0]         tdata_r;
    logic                tuser_r, tlast_r;
    logic                escape, iter_done, accept, line_end, frame_end;

    fractal_iter_step #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_step (
        .zr(zr), .zi(zi), .c_re(cr), .c_im(ci),
        .zr_next(zr_next), .zi_next(zi_next), .escape(escape)
    );

    assign iter_done = escape || (iter == max_iter_s);
    assign accept    = (state == OUT) && m.tready;
    assign line_end  = (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_enable) state_next = INIT;
            INIT:    state_next = ITER;
            ITER:    if (iter_done) state_next = OUT;
            OUT:     if (accept) state_next = frame_end ? IDLE : INIT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m.tvalid   = (state == OUT);
        m.tdata    = tdata_r;
        m.tuser    = tuser_r;
        m.tlast    = tlast_r;
        busy       = (state != IDLE);
        frame_done = accept && frame_end;
        dbg_state  = state;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            x <= '0;  y <= '0;  cur_re <= '0;  cur_im <= '0;
            x0_s <= '0;  dx_s <= '0;  dy_s <= '0;  c_re_s <= '0;  c_im_s <= '0;
            mode_s <= MODE_MANDEL;  max_iter_s <= ITER_W'(1);  iter <= '0;
            zr <= '0;  zi <= '0;  cr <= '0;  ci <= '0;
            tdata_r <= '0;  tuser_r <= 1'b0;  tlast_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cfg_enable) begin
                    mode_s     <= cfg_mode;
                    max_iter_s <= (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
                    x0_s <= cfg_x0;  dx_s <= cfg_dx;  dy_s <= cfg_dy;
                    c_re_s <= cfg_c_re;  c_im_s <= cfg_c_im;
                    x <= '0;  y <= '0;  cur_re <= cfg_x0;  cur_im <= cfg_y0;
                end
                INIT: begin
                    iter <= '0;
                    if (mode_s == MODE_JULIA) begin
                        zr <= cur_re;  zi <= cur_im;  cr <= c_re_s;  ci <= c_im_s;
                    end else begin
                        zr <= '0;  zi <= '0;  cr <= cur_re;  ci <= cur_im;
                    end
                end
                ITER: if (iter_done) begin
                    // Hitting the limit is black even if this step also escapes.
                    tdata_r <= grey_map(8'(iter), iter == max_iter_s);
                    tuser_r <= (x == '0) && (y == '0);
                    tlast_r <= line_end;
                end else begin
                    zr <= zr_next;  zi <= zi_next;  iter <= iter + 1'b1;
                end
                OUT: if (accept && !frame_end) begin
                    if (!line_end) begin
                        x <= x + 1'b1;  cur_re <= cur_re + dx_s;
                    end else begin
                        x <= '0;  y <= y + 1'b1;  cur_re <= x0_s;  cur_im <= cur_im + dy_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
